// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master FIFO bridge.
package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } spi_bridge_state_t;

    // Pointer width for a power-of-two FIFO depth; counts are one bit wider.
    function automatic int spi_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes into a full FIFO and pops
// from an empty one are ignored; fullness is judged on the pre-edge count.
// dout reads the head combinationally and is zero while empty.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [spi_ptr_w(DEPTH):0] count,
    output logic [WIDTH-1:0]          dout
);

    localparam int PW = spi_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because dout is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spi_master_fifo_bridge.sv
// Buffered front end for spi_module_master: TX FIFO feeds one SPI transaction
// per word, returned words land in an RX FIFO.
// Optional RX path enabled by defining SPI_BRIDGE_RX_EN; without it rx_* are
// tied to zero and m_miso_data / rx_ready are ignored.
//
// state    | meaning
// S_IDLE   | waiting for enable and a queued TX word
// S_LAUNCH | m_transmit_en pulse for the word just popped
// S_WAIT   | master shifting; wait for m_payload_done
// S_GAP    | one cycle for the master to drop CS
module spi_master_fifo_bridge
    import spi_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [PAYLOAD_BITS-1:0]       tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [PAYLOAD_BITS-1:0]       rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overflow,
    output logic                          busy,
    output logic                          m_spi_en,
    output logic                          m_transmit_en,
    output logic [PAYLOAD_BITS-1:0]       m_mosi_data,
    input  logic [PAYLOAD_BITS-1:0]       m_miso_data,
    input  logic                          m_payload_done
);

    spi_bridge_state_t state;
    spi_bridge_state_t state_nxt;

    logic                    tx_full;
    logic                    tx_empty;
    logic [PAYLOAD_BITS-1:0] tx_head;
    logic                    tx_pop;
    logic                    rx_push;

    assign tx_ready      = ~tx_full;
    assign busy          = (state != S_IDLE);
    assign m_spi_en      = (state != S_IDLE);
    assign m_transmit_en = (state == S_LAUNCH);

    spi_sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .din   (tx_data),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_level),
        .dout  (tx_head)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic plus the TX pop / RX push strobes.
    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && !tx_empty) begin
                    tx_pop    = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (m_payload_done) begin
                    rx_push   = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Word to the master is latched at the pop and held until the next one.
    always_ff @(posedge clk) begin
        if (rst)         m_mosi_data <= '0;
        else if (tx_pop) m_mosi_data <= tx_head;
    end

`ifdef SPI_BRIDGE_RX_EN
    logic                         rx_full;
    logic                         rx_empty;
    logic [$clog2(FIFO_DEPTH):0]  rx_count_unused;

    assign rx_valid = ~rx_empty;

    spi_sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (m_miso_data),
        .pop   (rx_ready),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count_unused),
        .dout  (rx_data)
    );

    // Sticky drop flag: a returned word arrived while the RX FIFO was full.
    always_ff @(posedge clk) begin
        if (rst)                  rx_overflow <= 1'b0;
        else if (rx_push && rx_full) rx_overflow <= 1'b1;
    end
`else
    logic unused_rx;

    assign unused_rx   = ^{m_miso_data, rx_ready, rx_push};
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
    assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_fifo_bridge.sv
// Self-checking bench for spi_master_fifo_bridge with a stub SPI master.
// TX words are queued as expected launches; returned words are queued as
// expected RX pops. Expectations for the RX path follow SPI_BRIDGE_RX_EN.
module tb_spi_master_fifo_bridge;

    localparam int PB    = 8;
    localparam int DEPTH = 16;
    localparam int LAT   = 4;
`ifdef SPI_BRIDGE_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          enable;
    logic [PB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [4:0]    tx_level;
    logic [PB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_overflow;
    logic          busy;
    logic          m_spi_en;
    logic          m_transmit_en;
    logic [PB-1:0] m_mosi_data;
    logic [PB-1:0] m_miso_data;
    logic          m_payload_done;

    spi_master_fifo_bridge #(
        .PAYLOAD_BITS (PB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_level       (tx_level),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_overflow    (rx_overflow),
        .busy           (busy),
        .m_spi_en       (m_spi_en),
        .m_transmit_en  (m_transmit_en),
        .m_mosi_data    (m_mosi_data),
        .m_miso_data    (m_miso_data),
        .m_payload_done (m_payload_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [PB-1:0] exp_tx[$];
    logic [PB-1:0] exp_rx[$];
    bit            exp_ovf;
    bit            inflight;
    int            stub_cnt;
    logic [PB-1:0] stub_pend;
    bit            stub_hold;
    bit            man_done;
    bit            chk_space;
    int            prev_launch;
    int            n_launch = 0;
    int            n_pop    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [PB-1:0] w);
        int k = 0;
        while (!tx_ready && k < 200) begin
            tick(1);
            k++;
        end
        chk("push_ready", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = w;
        exp_tx.push_back(w);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((busy || tx_level != 0) && k < 3000) begin
            tick(1);
            k++;
        end
        chk({tag, "_idle"}, {busy, tx_level}, 0);
    endtask

    // Monitor, RX model and stub master, all sampled at the falling edge.
    initial begin
        int sz0;
        m_payload_done = 1'b0;
        m_miso_data    = '0;
        stub_cnt       = 0;
        stub_pend      = '0;
        exp_ovf        = 1'b0;
        inflight       = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_tx.delete();
                exp_rx.delete();
                exp_ovf        = 1'b0;
                inflight       = 1'b0;
                stub_cnt       = 0;
                m_payload_done = 1'b0;
            end else begin
                sz0 = exp_rx.size();
                if (rx_valid && rx_ready) begin
                    n_pop++;
                    if (exp_rx.size() == 0) chk("rx_extra_pop", rx_valid, 0);
                    else                    chk("rx_data", rx_data, exp_rx.pop_front());
                end
                if (m_transmit_en) begin
                    n_launch++;
                    if (exp_tx.size() == 0) chk("launch_extra", m_transmit_en, 0);
                    else                    chk("mosi", m_mosi_data, exp_tx.pop_front());
                    if (chk_space && prev_launch >= 0) chk("spacing", cyc - prev_launch, 7);
                    prev_launch = cyc;
                    inflight = 1'b1;
                end
                m_payload_done = 1'b0;
                if (stub_cnt > 0) begin
                    stub_cnt--;
                    if (stub_cnt == 0) begin
                        m_payload_done = 1'b1;
                        m_miso_data    = stub_pend;
                    end
                end
                if (m_transmit_en && !stub_hold) begin
                    stub_cnt  = LAT;
                    stub_pend = m_mosi_data ^ 8'h99;
                end
                if (man_done) begin
                    m_payload_done = 1'b1;
                    m_miso_data    = 8'h77;
                    man_done       = 1'b0;
                end
                if (m_payload_done && inflight) begin
                    inflight = 1'b0;
                    if (RX_EN) begin
                        if (sz0 >= DEPTH) exp_ovf = 1'b1;
                        else              exp_rx.push_back(m_miso_data);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int p0;
        int k;
        rst         = 1'b1;
        enable      = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        rx_ready    = 1'b0;
        stub_hold   = 1'b0;
        man_done    = 1'b0;
        chk_space   = 1'b0;
        prev_launch = -1;

        // Reset values
        tick(3);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_ovf", rx_overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spi_en", m_spi_en, 0);
        chk("rst_tx_en", m_transmit_en, 0);
        chk("rst_mosi", m_mosi_data, 0);
        rst = 1'b0;
        tick(1);

        // Single word: launch two cycles after the write, RX one cycle after done
        enable = 1'b1;
        push_word(8'hA5);
        chk("single_pre_en", m_transmit_en, 0);
        chk("single_level", tx_level, 1);
        tick(1);
        chk("single_launch", m_transmit_en, 1);
        chk("single_mosi", m_mosi_data, 8'hA5);
        chk("single_spi_en", m_spi_en, 1);
        tick(1);
        chk("single_one_pulse", m_transmit_en, 0);
        tick(3);
        chk("single_wait_busy", busy, 1);
        chk("single_wait_rxv", rx_valid, 0);
        tick(1);
        chk("single_gap_busy", busy, 1);
        chk("single_rx_valid", rx_valid, RX_EN);
        chk("single_rx_data", rx_data, RX_EN ? 8'h3C : 8'h00);
        chk("single_mosi_hold", m_mosi_data, 8'hA5);
        tick(1);
        chk("single_idle", busy, 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("single_rx_empty", rx_valid, 0);

        // TX full then drain in order with 7-cycle launch spacing
        enable = 1'b0;
        for (int i = 0; i < 16; i++) push_word(8'(i));
        chk("full_ready", tx_ready, 0);
        chk("full_level", tx_level, 16);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tick(1);
        tx_valid = 1'b0;
        chk("full_reject", tx_level, 16);
        chk("full_no_launch", busy, 0);
        rx_ready    = 1'b1;
        base        = n_launch;
        prev_launch = -1;
        chk_space   = 1'b1;
        enable      = 1'b1;
        wait_drain("drain");
        tick(3);
        chk_space = 1'b0;
        chk("drain_launches", n_launch - base, 16);
        chk("drain_ready", tx_ready, 1);

        // RX overflow: 17 words with no consumer
        rx_ready = 1'b0;
        tick(1);
        for (int i = 1; i <= 17; i++) push_word(8'h40 + 8'(i));
        wait_drain("ovf");
        tick(2);
        chk("ovf_flag", rx_overflow, exp_ovf);
        chk("ovf_flag_set", rx_overflow, RX_EN);
        chk("ovf_rx_valid", rx_valid, RX_EN);
        p0 = n_pop;
        rx_ready = 1'b1;
        k = 0;
        while (rx_valid && k < 100) begin
            tick(1);
            k++;
        end
        rx_ready = 1'b0;
        chk("ovf_pops", n_pop - p0, RX_EN ? 16 : 0);
        chk("ovf_empty", rx_valid, 0);

        // Enable drop during S_WAIT with three words queued
        base = n_launch;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        enable = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            tick(1);
            k++;
        end
        tick(10);
        chk("drop_launches", n_launch - base, 1);
        chk("drop_level", tx_level, 2);
        chk("drop_busy", busy, 0);
        chk("drop_rx_valid", rx_valid, RX_EN);
        chk("drop_rx_data", rx_data, RX_EN ? 8'h88 : 8'h00);
        chk("drop_ovf_sticky", rx_overflow, RX_EN);

        // Reset during S_WAIT, then a stray payload_done
        stub_hold = 1'b1;
        enable    = 1'b1;
        k = 0;
        while (!m_transmit_en && k < 20) begin
            tick(1);
            k++;
        end
        chk("mid_launch", m_transmit_en, 1);
        tick(2);
        chk("mid_busy", busy, 1);
        base = n_launch;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_level", tx_level, 0);
        chk("mid_rst_rxv", rx_valid, 0);
        chk("mid_rst_ovf", rx_overflow, 0);
        chk("mid_rst_spi_en", m_spi_en, 0);
        chk("mid_rst_mosi", m_mosi_data, 0);
        man_done = 1'b1;
        tick(3);
        chk("stray_busy", busy, 0);
        chk("stray_rxv", rx_valid, 0);
        chk("stray_launch", n_launch - base, 0);
        stub_hold = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
